hilo_ctrl: RTL and testbench
============================

# hilo_ctrl

HI/LO register unit and multiply/divide sequencer for the MIPS core. It sits between the EX stage and the iterative signed divider. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, drives the divider's start/operand handshake, runs an internal 32-cycle shift-add multiplier, and writes HI/LO. It also raises `busy` so the pipeline stalls MFHI/MFLO and further mult/div issues.

## Interface
- DIV_CYCLES, 1, cycles `div_start` is held high per division (1..15)
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- issue  in  1  EX presents an operation this cycle
- op  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 treated as NOP
- rs_data  in  32  rs operand (dividend / multiplicand / MTxx source)
- rt_data  in  32  rt operand (divisor / multiplier)
- div_start  out  1  divider start
- div_unsigned  out  1  high for DIVU
- div_dividend  out  32  held operand
- div_divisor  out  32  held operand
- div_q  in  32  divider quotient
- div_r  in  32  divider remainder
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  operation in flight; pipeline must stall

## Operation
- States: IDLE, MUL, DIV_RUN, DIV_CAP. `busy` = state != IDLE.
- Acceptance: an issue is accepted only when `issue && !busy`. An issue while busy is ignored; EX must stall on `busy`.
- MTHI/MTLO: write `rs_data` to HI/LO at the accept edge. State stays IDLE.
- MULT/MULTU:
  - At accept, latch the operand magnitudes. For MULT, take the two's-complement magnitude of each negative operand; MULTU uses operands raw. Latch the sign flag as rs[31]^rt[31] for MULT, 0 for MULTU.
  - Clear the 64-bit accumulator, go to MUL with count = 0.
  - Each MUL cycle: if multiplier bit[count] is set, accumulator += multiplicand << count; count++.
  - At count == 31, write {HI,LO} = sign ? -acc : acc, then go to IDLE.
- DIV/DIVU:
  - If rt_data == 0, write HI = rs_data and LO = 32'hFFFF_FFFF at the accept edge. No divider handshake, stay IDLE.
  - Otherwise latch the operands into `div_dividend`/`div_divisor` and go to DIV_RUN with a counter.
  - DIV_RUN: `div_start` = 1 for DIV_CYCLES cycles.
  - DIV_CAP: `div_start` = 0 with operands still held. At the end of this cycle, LO = `div_q` and HI = `div_r`; go to IDLE.
  - The divider operands are held constant from accept until leaving DIV_CAP.
- `div_unsigned` = latched op == DIVU. It is 0 outside division.
- Reset (low at an edge):
  - HI = LO = 0, state IDLE, counters 0.
  - `div_start` = 0; `div_dividend`, `div_divisor` and `div_unsigned` = 0.
  - An in-flight operation is abandoned and HI/LO are not written.

## Timing
- Cycle 0 is the accept cycle.
- MTHI/MTLO, and division by zero: new HI/LO are visible in cycle 1; `busy` never asserts.
- MULT/MULTU (iterative): `busy` is high in cycles 1..32; HI/LO are updated and `busy` is low in cycle 33.
- DIV/DIVU: `div_start` is high in cycles 1..DIV_CYCLES; DIV_CAP is cycle DIV_CYCLES+1; HI/LO are updated in cycle DIV_CYCLES+2. `busy` spans DIV_CYCLES+1 cycles.
- `hi`/`lo` are registered outputs. A same-cycle reader sees the old value.
- On an edge where reset is asserted and an issue is present, reset wins.

## Configuration
- HILO_FAST_MULT_EN defined: MULT/MULTU compute a single-cycle 64-bit product (signed or unsigned) and write HI/LO at the accept edge. MUL state is never entered and `busy` does not assert for multiplies.
- Not defined: the iterative 32-cycle multiplier described above.

## Test plan
- Reset low for 2 cycles mid-MULT, then release -> HI = LO = 0, `busy` = 0, and the abandoned result is never written.
- MULT rs = -3 (32'hFFFF_FFFD), rt = 7 -> `busy` high for exactly 32 cycles, then HI = 32'hFFFF_FFFF, LO = 32'hFFFF_FFEB. The fast build gives the same values with `busy` never high.
- MULTU rs = rt = 32'hFFFF_FFFF -> HI = 32'hFFFF_FFFE, LO = 32'h0000_0001.
- DIV rs = -7, rt = 2, DIV_CYCLES = 1 with the divider model -> `div_start` high for 1 cycle with operands stable through DIV_CAP; LO = 32'hFFFF_FFFD, HI = 32'hFFFF_FFFF in cycle 3.
- DIV rs = 5, rt = 0 -> no `div_start`; HI = 5, LO = 32'hFFFF_FFFF in cycle 1; `busy` = 0.
- MTHI 32'h1234_5678 issued while a DIV is busy -> ignored and HI keeps the division result. MTLO 32'hA5A5_A5A5 issued once idle -> LO = 32'hA5A5_A5A5 next cycle.

Source files
------------

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: HI/LO registers, iterative shift-add multiplier and divider handshake sequencer.
// Optional macro HILO_FAST_MULT_EN selects a single-cycle multiplier instead of the 32-cycle one.
module hilo_ctrl #(
    parameter int unsigned DIV_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        div_start,
    output logic        div_unsigned,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned PW    = 2 * XLEN;
    localparam int unsigned CNT_W = 5;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV_RUN,
        S_DIV_CAP
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [XLEN-1:0]   mcand, mcand_d;
    logic [XLEN-1:0]   mplier, mplier_d;
    logic [PW-1:0]     acc, acc_d;
    logic              sign, sign_d;
    logic [XLEN-1:0]   hi_d, lo_d, dvd_d, dvs_d;
    logic              dun_d;

    logic [PW-1:0]     partial, acc_sum, acc_res;

`ifdef HILO_FAST_MULT_EN
    // Sign-extend only for MULT; the low 64 bits of the product are exact either way.
    logic              mul_sx;
    logic [PW-1:0]     prod;
    assign mul_sx = (op == OP_MULT);
    assign prod   = {{XLEN{mul_sx & rs_data[XLEN-1]}}, rs_data}
                  * {{XLEN{mul_sx & rt_data[XLEN-1]}}, rt_data};
`else
    logic [XLEN-1:0]   rs_mag, rt_mag;
    assign rs_mag = (op == OP_MULT && rs_data[XLEN-1]) ? (~rs_data + 32'd1) : rs_data;
    assign rt_mag = (op == OP_MULT && rt_data[XLEN-1]) ? (~rt_data + 32'd1) : rt_data;
`endif

    // One shift-add step; the final step is folded into the HI/LO write.
    assign partial = mplier[cnt] ? (PW'(mcand) << cnt) : '0;
    assign acc_sum = acc + partial;
    assign acc_res = sign ? (~acc_sum + 64'd1) : acc_sum;

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        mcand_d  = mcand;
        mplier_d = mplier;
        acc_d    = acc;
        sign_d   = sign;
        hi_d     = hi;
        lo_d     = lo;
        dvd_d    = div_dividend;
        dvs_d    = div_divisor;
        dun_d    = div_unsigned;

        unique case (state)
            S_IDLE: begin
                if (issue) begin
                    unique case (op)
                        OP_MTHI: hi_d = rs_data;
                        OP_MTLO: lo_d = rs_data;
                        OP_MULT, OP_MULTU: begin
`ifdef HILO_FAST_MULT_EN
                            {hi_d, lo_d} = prod;
`else
                            mcand_d  = rs_mag;
                            mplier_d = rt_mag;
                            sign_d   = (op == OP_MULT) & (rs_data[XLEN-1] ^ rt_data[XLEN-1]);
                            acc_d    = '0;
                            cnt_d    = '0;
                            state_d  = S_MUL;
`endif
                        end
                        OP_DIV, OP_DIVU: begin
                            if (rt_data == '0) begin
                                hi_d = rs_data;
                                lo_d = 32'hFFFF_FFFF;
                            end else begin
                                dvd_d   = rs_data;
                                dvs_d   = rt_data;
                                dun_d   = (op == OP_DIVU);
                                cnt_d   = '0;
                                state_d = S_DIV_RUN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                acc_d = acc_sum;
                if (cnt == 5'd31) begin
                    {hi_d, lo_d} = acc_res;
                    cnt_d        = '0;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt + 5'd1;
                end
            end
            S_DIV_RUN: begin
                if (cnt == CNT_W'(DIV_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DIV_CAP;
                end else begin
                    cnt_d = cnt + 5'd1;
                end
            end
            S_DIV_CAP: begin
                hi_d    = div_r;
                lo_d    = div_q;
                dun_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // busy and div_start are registered copies of the next-state decode.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            acc          <= '0;
            sign         <= 1'b0;
            hi           <= '0;
            lo           <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
            div_unsigned <= 1'b0;
            div_start    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            mcand        <= mcand_d;
            mplier       <= mplier_d;
            acc          <= acc_d;
            sign         <= sign_d;
            hi           <= hi_d;
            lo           <= lo_d;
            div_dividend <= dvd_d;
            div_divisor  <= dvs_d;
            div_unsigned <= dun_d;
            div_start    <= (state_d == S_DIV_RUN);
            busy         <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Scoreboard bench for hilo_ctrl: stimulus pushes per-cycle expectations, a monitor compares at negedge.
module tb_hilo_ctrl;

    localparam int unsigned DC = 1;
`ifdef HILO_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    localparam logic [2:0] OP_NOP7 = 3'd7;
    localparam logic [2:0] OP_MULT = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_DIVU = 3'd4;
    localparam logic [2:0] OP_MTHI = 3'd5;
    localparam logic [2:0] OP_MTLO = 3'd6;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        issue = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_data = '0, rt_data = '0;
    logic        div_start, div_unsigned, busy;
    logic [31:0] div_dividend, div_divisor, div_q, div_r, hi, lo;

    hilo_ctrl #(.DIV_CYCLES(DC)) dut (
        .clock(clock), .reset(reset), .issue(issue), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .div_start(div_start), .div_unsigned(div_unsigned),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_q(div_q), .div_r(div_r),
        .hi(hi), .lo(lo), .busy(busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural divider: quotient/remainder of the held operands.
    always_comb begin
        if (div_divisor == 32'd0) begin
            div_q = '0;
            div_r = '0;
        end else if (div_unsigned) begin
            div_q = div_dividend / div_divisor;
            div_r = div_dividend % div_divisor;
        end else begin
            div_q = 32'($signed(div_dividend) / $signed(div_divisor));
            div_r = 32'($signed(div_dividend) % $signed(div_divisor));
        end
    end

    typedef struct {
        int          cyc;
        logic [31:0] hi, lo;
        logic        busy, ds, du, chk_ops;
        logic [31:0] dvd, dvs;
        string       name;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    int          n_chk = 0, n_fail = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    always @(negedge clock) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            n_chk++;
            if (e.cyc < cyc) begin
                n_fail++;
                $display("FAIL %s: check for cycle %0d missed at cycle %0d", e.name, e.cyc, cyc);
            end else if (hi !== e.hi || lo !== e.lo || busy !== e.busy || div_start !== e.ds ||
                         div_unsigned !== e.du ||
                         (e.chk_ops && (div_dividend !== e.dvd || div_divisor !== e.dvs))) begin
                n_fail++;
                $display("FAIL %s @%0d: got hi=%h lo=%h busy=%b ds=%b du=%b dvd=%h dvs=%h; want hi=%h lo=%h busy=%b ds=%b du=%b dvd=%h dvs=%h (ops checked=%b)",
                         e.name, cyc, hi, lo, busy, div_start, div_unsigned, div_dividend, div_divisor,
                         e.hi, e.lo, e.busy, e.ds, e.du, e.dvd, e.dvs, e.chk_ops);
            end
        end
    end

    task automatic push(input int c, input logic [31:0] h, input logic [31:0] l, input logic b,
                        input logic ds, input logic du, input logic co,
                        input logic [31:0] dvd, input logic [31:0] dvs, input string nm);
        exp_t x;
        x.cyc = c; x.hi = h; x.lo = l; x.busy = b; x.ds = ds; x.du = du;
        x.chk_ops = co; x.dvd = dvd; x.dvs = dvs; x.name = nm;
        sbq.push_back(x);
    endtask

    task automatic push_idle(input int c, input logic [31:0] h, input logic [31:0] l, input string nm);
        push(c, h, l, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, nm);
    endtask

    // Called at a negedge; presents the op for one cycle.
    task automatic issue_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; rs_data = a; rt_data = b; issue = 1'b1;
        @(negedge clock);
        issue = 1'b0;
    endtask

    task automatic run_mt(input logic [2:0] o, input logic [31:0] a, input string nm);
        int c0 = cyc;
        if (o == OP_MTHI) m_hi = a; else m_lo = a;
        push_idle(c0 + 1, m_hi, m_lo, nm);
        issue_op(o, a, 32'h0);
    endtask

    task automatic run_mult(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] r, input string nm);
        int c0 = cyc;
        for (int k = 1; k <= MUL_LAT; k++) begin
            if (k < MUL_LAT) push(c0 + k, m_hi, m_lo, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, nm);
            else             push_idle(c0 + k, r[63:32], r[31:0], nm);
        end
        issue_op(o, a, b);
        m_hi = r[63:32];
        m_lo = r[31:0];
        repeat (MUL_LAT) @(negedge clock);
    endtask

    task automatic run_div(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] q, input logic [31:0] r, input string nm);
        int   c0 = cyc;
        logic du = (o == OP_DIVU);
        if (b == 32'd0) begin
            push_idle(c0 + 1, a, 32'hFFFF_FFFF, nm);
            issue_op(o, a, b);
            m_hi = a;
            m_lo = 32'hFFFF_FFFF;
            @(negedge clock);
        end else begin
            for (int k = 1; k <= int'(DC); k++)
                push(c0 + k, m_hi, m_lo, 1'b1, 1'b1, du, 1'b1, a, b, nm);
            push(c0 + DC + 1, m_hi, m_lo, 1'b1, 1'b0, du, 1'b1, a, b, nm);
            push_idle(c0 + DC + 2, r, q, nm);
            issue_op(o, a, b);
            m_hi = r;
            m_lo = q;
            repeat (DC + 2) @(negedge clock);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        repeat (2) @(negedge clock);
        push_idle(cyc + 1, 32'h0, 32'h0, "reset_state");
        push_idle(cyc + 2, 32'h0, 32'h0, "reset_state2");
        reset = 1'b1;
        repeat (2) @(negedge clock);

        c0 = cyc;
        push_idle(c0 + 1, m_hi, m_lo, "op7_nop");
        issue_op(OP_NOP7, 32'hDEAD_BEEF, 32'h1);

        run_mt(OP_MTHI, 32'h1111_2222, "mthi");
        run_mt(OP_MTLO, 32'h3333_4444, "mtlo");

        run_mult(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, "mult_neg3x7");
        run_mult(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu_max");
        run_mult(OP_MULT,  32'hFFFF_FFFB, 32'hFFFF_FFFA, 64'h0000_0000_0000_001E, "mult_neg5xneg6");

        // Reset for two cycles mid-multiply, with an MTHI presented during reset.
        c0 = cyc;
        for (int k = 1; k <= 5; k++) begin
            if (k < MUL_LAT) push(c0 + k, m_hi, m_lo, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, "midmul_busy");
            else             push_idle(c0 + k, 32'h0, 32'h0000_000C, "midmul_fast");
        end
        push_idle(c0 + 6, 32'h0, 32'h0, "midmul_reset");
        push_idle(c0 + 7, 32'h0, 32'h0, "reset_beats_issue");
        push_idle(c0 + 40, 32'h0, 32'h0, "abandoned_not_written");
        issue_op(OP_MULT, 32'h3, 32'h4);
        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        op = OP_MTHI; rs_data = 32'hDEAD_0001; issue = 1'b1;
        @(negedge clock);
        issue = 1'b0;
        reset = 1'b1;
        m_hi = '0;
        m_lo = '0;
        repeat (34) @(negedge clock);

        run_div(OP_DIV,  32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div_neg7by2");
        run_div(OP_DIVU, 32'd100, 32'd7, 32'h0000_000E, 32'h0000_0002, "divu_100by7");
        run_div(OP_DIV,  32'd5, 32'd0, 32'h0, 32'h0, "div_by_zero");
        run_div(OP_DIVU, 32'hFFFF_FFF9, 32'h2, 32'h7FFF_FFFC, 32'h0000_0001, "divu_big");

        // MTHI while busy is dropped; MTLO once idle lands.
        c0 = cyc;
        for (int k = 1; k <= int'(DC); k++)
            push(c0 + k, m_hi, m_lo, 1'b1, 1'b1, 1'b0, 1'b1, 32'd20, 32'd3, "div_mthi_run");
        push(c0 + DC + 1, m_hi, m_lo, 1'b1, 1'b0, 1'b0, 1'b1, 32'd20, 32'd3, "div_mthi_cap");
        push_idle(c0 + DC + 2, 32'd2, 32'd6, "mthi_ignored");
        push_idle(c0 + DC + 3, 32'd2, 32'hA5A5_A5A5, "mtlo_after_div");
        issue_op(OP_DIV, 32'd20, 32'd3);
        issue_op(OP_MTHI, 32'h1234_5678, 32'h0);
        repeat (DC) @(negedge clock);
        issue_op(OP_MTLO, 32'hA5A5_A5A5, 32'h0);
        m_hi = 32'd2;
        m_lo = 32'hA5A5_A5A5;

        repeat (3) @(negedge clock);
        n_chk++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
